statemover_ctrl: RTL and testbench

//  Hardware sequencer for state save/restore around a clock-enabled user design.

---
 rtl/statemover_if.sv | 28 ++
 rtl/statemover_ctrl.sv | 164 ++++++++++++++++
 tb/tb_statemover_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/statemover_if.sv
// Host-side bundle for the state-save/restore sequencer: request inputs,
// breakpoint, and the clock-enable / strobe / status outputs.
interface statemover_if #(
  parameter int unsigned CNT_W = 32
);
  logic             load;
  logic             dump;
  logic             resume;
  logic [CNT_W-1:0] breakpoint;
  logic             clk_en;
  logic             restore;
  logic             save;
  logic             busy;
  logic             halted;
  logic             done;
  logic             req_drop;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output load, dump, resume, breakpoint,
    input  clk_en, restore, save, busy, halted, done, req_drop, cycle_count
  );

  modport slave (
    input  load, dump, resume, breakpoint,
    output clk_en, restore, save, busy, halted, done, req_drop, cycle_count
  );
endinterface

// File: rtl/statemover_ctrl.sv
// Sequencer that freezes the user design (clk_en low), waits a settle window,
// pulses save/restore to the state-transfer engine, then returns to RUN or HALT.
// Also counts enabled cycles and halts at a programmable breakpoint.
module statemover_ctrl #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned QUIESCE_CYCLES = 2,
  parameter int unsigned ACTION_CYCLES  = 2
) (
  input  logic         clk,
  input  logic         reset,
  statemover_if.slave  bus
);

  localparam int unsigned MAX_CYC = (QUIESCE_CYCLES > ACTION_CYCLES) ? QUIESCE_CYCLES : ACTION_CYCLES;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0] Q_LAST = TMR_W'(QUIESCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] A_LAST = TMR_W'(ACTION_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_QUIESCE,
    ST_ACTION,
    ST_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             op_load_q, op_load_d;
  logic             origin_halt_q, origin_halt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             load_q, dump_q, resume_q;

  logic clk_en_q, clk_en_d;
  logic restore_q, restore_d;
  logic save_q, save_d;
  logic busy_q, busy_d;
  logic halted_q, halted_d;
  logic done_q, done_d;
  logic req_drop_q, req_drop_d;

  logic load_edge, dump_edge, resume_edge, req_edge, bp_hit;

  // Next-state, counter and registered-output decode.
  // Outputs are decoded from the next state so every port is a plain flop.
  always_comb begin
    load_edge     = bus.load & ~load_q;
    dump_edge     = bus.dump & ~dump_q;
    resume_edge   = bus.resume & ~resume_q;
    req_edge      = load_edge | dump_edge;
    bp_hit        = (count_q == bus.breakpoint) && (bus.breakpoint != '1);

    state_d       = state_q;
    tmr_d         = tmr_q;
    op_load_d     = op_load_q;
    origin_halt_d = origin_halt_q;
    count_d       = count_q;
    done_d        = 1'b0;
    req_drop_d    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (req_edge) begin
          state_d       = ST_QUIESCE;
          tmr_d         = '0;
          op_load_d     = load_edge;
          origin_halt_d = 1'b0;
        end else if (bp_hit) begin
          state_d = ST_HALT;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ST_QUIESCE: begin
        req_drop_d = req_edge;
        if (tmr_q == Q_LAST) begin
          state_d = ST_ACTION;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_ACTION: begin
        req_drop_d = req_edge;
        if (tmr_q == A_LAST) begin
          state_d = origin_halt_q ? ST_HALT : ST_RUN;
          done_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_HALT: begin
        // A transfer request outranks a simultaneous resume.
        if (req_edge) begin
          state_d       = ST_QUIESCE;
          tmr_d         = '0;
          op_load_d     = load_edge;
          origin_halt_d = 1'b1;
        end else if (resume_edge) begin
          state_d = ST_RUN;
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    clk_en_d  = (state_d == ST_RUN);
    busy_d    = (state_d == ST_QUIESCE) || (state_d == ST_ACTION);
    halted_d  = (state_d == ST_HALT) || (busy_d && origin_halt_d);
    restore_d = (state_d == ST_ACTION) && op_load_d;
    save_d    = (state_d == ST_ACTION) && !op_load_d;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Datapath, edge history and output registers; history resets high so
  // inputs held across reset do not look like requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q         <= '0;
      op_load_q     <= 1'b0;
      origin_halt_q <= 1'b0;
      count_q       <= '0;
      load_q        <= 1'b1;
      dump_q        <= 1'b1;
      resume_q      <= 1'b1;
      clk_en_q      <= 1'b1;
      restore_q     <= 1'b0;
      save_q        <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      done_q        <= 1'b0;
      req_drop_q    <= 1'b0;
    end else begin
      tmr_q         <= tmr_d;
      op_load_q     <= op_load_d;
      origin_halt_q <= origin_halt_d;
      count_q       <= count_d;
      load_q        <= bus.load;
      dump_q        <= bus.dump;
      resume_q      <= bus.resume;
      clk_en_q      <= clk_en_d;
      restore_q     <= restore_d;
      save_q        <= save_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
      done_q        <= done_d;
      req_drop_q    <= req_drop_d;
    end
  end

  assign bus.clk_en      = clk_en_q;
  assign bus.restore     = restore_q;
  assign bus.save        = save_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.done        = done_q;
  assign bus.req_drop    = req_drop_q;
  assign bus.cycle_count = count_q;

endmodule

// File: tb/tb_statemover_ctrl.sv
// Scoreboard bench for statemover_ctrl: a timeline reference model predicts
// each cycle's outputs from request timestamps; a monitor compares them.
module tb_statemover_ctrl;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned QC    = 2;
  localparam int unsigned AC    = 2;
  localparam logic [CNT_W-1:0] ALL1 = '1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  statemover_if #(.CNT_W(CNT_W)) bus ();

  statemover_ctrl #(
    .CNT_W(CNT_W),
    .QUIESCE_CYCLES(QC),
    .ACTION_CYCLES(AC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int               tgt;
    logic [6:0]       flags;  // {clk_en, restore, save, busy, halted, done, req_drop}
    logic [CNT_W-1:0] count;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: cycle-numbered timeline of the current transfer.
  logic [CNT_W-1:0] m_count;
  bit               m_halted;
  int               m_xt;
  bit               m_xload;
  bit               pl, pd, pr;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endfunction

  function automatic void model_reset();
    m_count  = '0;
    m_halted = 1'b0;
    m_xt     = -1000;
    m_xload  = 1'b0;
    pl = 1'b1; pd = 1'b1; pr = 1'b1;
  endfunction

  function automatic bit in_xfer(int c);
    return (c > m_xt) && (c <= m_xt + int'(QC + AC));
  endfunction

  // Advance one cycle (inputs held during cycle cyc) and predict cycle cyc+1.
  function automatic void model_step(bit l, bit d, bit r, logic [CNT_W-1:0] bp);
    int   k  = cyc;
    int   k1 = cyc + 1;
    bit   le = l & ~pl;
    bit   de = d & ~pd;
    bit   re = r & ~pr;
    bit   drop = 1'b0;
    bit   strobe;
    bit   busy;
    exp_t e;
    if (in_xfer(k)) begin
      drop = le | de;
    end else if (le | de) begin
      m_xt    = k;
      m_xload = le;
    end else if (!m_halted) begin
      if (m_count == bp && bp != ALL1) m_halted = 1'b1;
      else                            m_count  = m_count + 1;
    end else if (re) begin
      m_halted = 1'b0;
      m_count  = m_count + 1;
    end
    pl = l; pd = d; pr = r;
    busy   = in_xfer(k1);
    strobe = (k1 > m_xt + int'(QC)) && busy;
    e.tgt   = k1;
    e.flags = {!m_halted && !busy, strobe && m_xload, strobe && !m_xload, busy,
               m_halted, (k1 == m_xt + int'(QC + AC) + 1), drop};
    e.count = m_count;
    sb.push_back(e);
  endfunction

  function automatic void push_reset_state();
    exp_t e;
    e.tgt   = cyc;
    e.flags = 7'b1000000;
    e.count = '0;
    sb.push_back(e);
  endfunction

  // Monitor: compares whatever expectation is due for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      while (sb.size() > 0 && sb[0].tgt < cyc) begin
        e = sb.pop_front();
        check("scoreboard_stale", 64'(e.tgt), 64'(cyc));
      end
      if (sb.size() > 0 && sb[0].tgt == cyc) begin
        e = sb.pop_front();
        check("flags", 64'({bus.clk_en, bus.restore, bus.save, bus.busy,
                            bus.halted, bus.done, bus.req_drop}), 64'(e.flags));
        check("cycle_count", 64'(bus.cycle_count), 64'(e.count));
      end
    end
  end

  task automatic step(input bit l, input bit d, input bit r, input logic [CNT_W-1:0] bp);
    bus.load       = l;
    bus.dump       = d;
    bus.resume     = r;
    bus.breakpoint = bp;
    model_step(l, d, r, bp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [CNT_W-1:0] bp);
    repeat (n) step(1'b0, 1'b0, 1'b0, bp);
  endtask

  task automatic run_until_halt(input logic [CNT_W-1:0] bp);
    int n = 0;
    while (!m_halted && n < 64) begin
      step(1'b0, 1'b0, 1'b0, bp);
      n++;
    end
  endtask

  // Asynchronous reset in mid-cycle; outputs must settle before any clock edge.
  task automatic do_reset();
    sb.delete();
    reset = 1'b1;
    #2;
    check("async_rst_save", 64'(bus.save), 64'(0));
    check("async_rst_restore", 64'(bus.restore), 64'(0));
    check("async_rst_clk_en", 64'(bus.clk_en), 64'(1));
    check("async_rst_count", 64'(bus.cycle_count), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    push_reset_state();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CNT_W-1:0] bp;
    int               n;
    bus.load       = 1'b1;
    bus.dump       = 1'b0;
    bus.resume     = 1'b0;
    bus.breakpoint = ALL1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    push_reset_state();

    // Load held high through reset release: counting only.
    repeat (5) step(1'b1, 1'b0, 1'b0, ALL1);

    // Dump edge at count 10.
    n = 0;
    while (m_count != 10 && n < 32) begin
      step(1'b0, 1'b0, 1'b0, ALL1);
      n++;
    end
    step(1'b0, 1'b1, 1'b0, ALL1);
    idle(7, ALL1);

    // Breakpoint at 20, load from HALT, then resume.
    run_until_halt(CNT_W'(20));
    idle(3, CNT_W'(20));
    step(1'b1, 1'b0, 1'b0, CNT_W'(20));
    idle(8, CNT_W'(20));
    step(1'b0, 1'b0, 1'b1, CNT_W'(20));
    idle(3, CNT_W'(20));

    // Simultaneous load/dump, then dump edge during ACTION.
    step(1'b1, 1'b1, 1'b0, ALL1);
    idle(2, ALL1);
    step(1'b0, 1'b1, 1'b0, ALL1);
    idle(6, ALL1);

    // Resume and load edges together in HALT.
    bp = m_count + 3;
    run_until_halt(bp);
    step(1'b1, 1'b0, 1'b1, bp);
    idle(7, bp);
    step(1'b0, 1'b0, 1'b1, bp);
    idle(3, ALL1);

    // Request and breakpoint match in the same cycle.
    bp = m_count + 2;
    idle(2, bp);
    step(1'b0, 1'b1, 1'b0, bp);
    idle(7, bp);
    step(1'b0, 1'b0, 1'b1, ALL1);
    idle(2, ALL1);

    // Reset during ACTION of a save, then free-run with breakpoint disabled.
    step(1'b0, 1'b1, 1'b0, ALL1);
    idle(3, ALL1);
    do_reset();
    idle(40, ALL1);

    // Randomized traffic with moving breakpoints and occasional resets.
    bp = ALL1;
    for (int i = 0; i < 800; i++) begin
      if (i % 25 == 0) bp = ($urandom_range(0, 2) != 0) ? m_count + $urandom_range(0, 12) : ALL1;
      if ($urandom_range(0, 249) == 0) do_reset();
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 4) == 0), bp);
    end

    idle(2, ALL1);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
